// File: rtl/grace_bus_arbiter_if.sv
// One Grace register-bus link: a master holds CS (with WR/Ad/WD stable) until
// the slave side answers with a one-cycle Ac carrying RD.
interface grace_bus_arbiter_if;
   logic        cs;
   logic        wr;
   logic [11:0] ad;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ac;

   modport master (output cs, wr, ad, wd, input  rd, ac);
   modport slave  (input  cs, wr, ad, wd, output rd, ac);
endinterface

// File: rtl/grace_bus_arbiter.sv
// Two-master round-robin arbiter for the Grace register bus, with registered
// slave-side outputs and a per-access timeout that fabricates an error ack.
module grace_bus_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                Grace_Ck,
   input  logic                Grace_Rs_n,
   grace_bus_arbiter_if.slave  m0,
   grace_bus_arbiter_if.slave  m1,
   grace_bus_arbiter_if.master s,
   output logic                Timeout_Err,
   input  logic                Err_Clr,
   output logic                Gnt_Id
);

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        gnt_q;
   logic        s_cs_q;
   logic        s_wr_q;
   logic [11:0] s_ad_q;
   logic [31:0] s_wd_q;
   logic [31:0] m0_rd_q;
   logic [31:0] m1_rd_q;
   logic        m0_ac_q;
   logic        m1_ac_q;
   logic        err_q;

   logic        win_d;
   logic        gnt_cs;
   logic        done_d;
   logic [31:0] rd_d;

   // On a tie the master that was not granted last time wins.
   always_comb begin
      win_d = m1.cs;
      if (m0.cs && m1.cs) win_d = ~gnt_q;
   end

   assign gnt_cs = gnt_q ? m1.cs : m0.cs;
   assign done_d = s.ac || (cnt_q == CNT_LAST);
   assign rd_d   = s.ac ? s.rd : ERR_DATA;

   always_ff @(posedge Grace_Ck) begin
      if (!Grace_Rs_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         gnt_q   <= 1'b1;
         s_cs_q  <= 1'b0;
         s_wr_q  <= 1'b0;
         s_ad_q  <= 12'd0;
         s_wd_q  <= 32'd0;
         m0_rd_q <= 32'd0;
         m1_rd_q <= 32'd0;
         m0_ac_q <= 1'b0;
         m1_ac_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         m0_ac_q <= 1'b0;
         m1_ac_q <= 1'b0;
         // NOTE: the last non-blocking assignment wins, so a timeout set below overrides this clear.
         if (Err_Clr) err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (m0.cs || m1.cs) begin
                  gnt_q   <= win_d;
                  s_cs_q  <= 1'b1;
                  s_wr_q  <= win_d ? m1.wr : m0.wr;
                  s_ad_q  <= win_d ? m1.ad : m0.ad;
                  s_wd_q  <= win_d ? m1.wd : m0.wd;
                  cnt_q   <= 8'd0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               cnt_q <= cnt_q + 8'd1;
               if (done_d) begin
                  s_cs_q <= 1'b0;
                  if (gnt_q) begin
                     m1_rd_q <= rd_d;
                     m1_ac_q <= 1'b1;
                  end else begin
                     m0_rd_q <= rd_d;
                     m0_ac_q <= 1'b1;
                  end
                  if (!s.ac) err_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Hold off until the served master releases CS so it is not granted twice.
               if (!gnt_cs) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s.cs        = s_cs_q;
   assign s.wr        = s_wr_q;
   assign s.ad        = s_ad_q;
   assign s.wd        = s_wd_q;
   assign m0.rd       = m0_rd_q;
   assign m0.ac       = m0_ac_q;
   assign m1.rd       = m1_rd_q;
   assign m1.ac       = m1_ac_q;
   assign Timeout_Err = err_q;
   assign Gnt_Id      = gnt_q;

endmodule
